// File: rtl/rossler_pkg.sv
// Shared types, Q-format constants and saturating add/sub for the Rossler integrator.
// Arithmetic helpers run on a 64-bit carrier so any WIDTH up to 63 bits can use them.
package rossler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StM1,
    StM2,
    StM3,
    StM4,
    StM5,
    StUpd,
    StOut
  } state_e;

  localparam int unsigned MAX_W = 64;

  // Reference format: Q11.20 in a 32-bit word.
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_FRAC  = 20;
  localparam logic signed [MAX_W-1:0] ONE     = 64'sd1 <<< DEF_FRAC;
  localparam logic signed [MAX_W-1:0] SAT_MAX = (64'sd1 <<< (DEF_WIDTH - 1)) - 64'sd1;
  localparam logic signed [MAX_W-1:0] SAT_MIN = -(64'sd1 <<< (DEF_WIDTH - 1));

  // Operands are sign-extended WIDTH-bit values, so the sum never overflows the carrier.
  function automatic logic signed [MAX_W-1:0] sat_addsub(input logic signed [MAX_W-1:0] a,
                                                         input logic signed [MAX_W-1:0] b,
                                                         input logic                    sub,
                                                         input int unsigned             width);
    logic signed [MAX_W-1:0] sum;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sum = sub ? (a - b) : (a + b);
    hi  = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    lo  = ~hi;
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, floor shift by FRAC,
// clamp to the WIDTH-bit signed range.
module fx_mul_sat #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 20
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] PMax = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] PMin = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shr;

  always_comb begin
    // Low 2W bits of the sign-extended product equal the exact signed product.
    prod = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    shr  = prod >>> FRAC;
    if (shr > PMax) begin
      p_o = PMax[WIDTH-1:0];
    end else if (shr < PMin) begin
      p_o = PMin[WIDTH-1:0];
    end else begin
      p_o = shr[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rossler_tm.sv
// Time-multiplexed forward-Euler Rossler integrator: one shared saturating multiplier,
// six cycles per step, decimated output with valid/ready handshake and graceful stop.
module rossler_tm
  import rossler_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FRAC    = 20,
  parameter int unsigned DECIM_W = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   c_i,
  input  logic [WIDTH-1:0]   h_i,
  input  logic [WIDTH-1:0]   x0_i,
  input  logic [WIDTH-1:0]   y0_i,
  input  logic [WIDTH-1:0]   z0_i,
  input  logic [DECIM_W-1:0] decim_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   xn_o,
  output logic [WIDTH-1:0]   yn_o,
  output logic [WIDTH-1:0]   zn_o,
  output logic [CNT_W-1:0]   steps_o,
  output logic               busy_o
);

  function automatic logic signed [MAX_W-1:0] sext(input logic [WIDTH-1:0] v);
    return {{(MAX_W - WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] sat2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             sub);
    logic signed [MAX_W-1:0] r;
    r = sat_addsub(sext(a), sext(b), sub, WIDTH);
    return r[WIDTH-1:0];
  endfunction

  state_e state_q, state_d;

  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, h_q, h_d;
  logic [WIDTH-1:0]   p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d, p5_q, p5_d;
  logic [DECIM_W-1:0] decim_q, decim_d, dcnt_q, dcnt_d, dcnt_inc;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               stop_q, stop_d, stop_pend;

  logic [WIDTH-1:0]   mul_a, mul_b, mul_p;

  fx_mul_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign dcnt_inc  = dcnt_q + DECIM_W'(1);
  assign stop_pend = stop_q | stop_i;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    h_d     = h_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    p4_d    = p4_q;
    p5_d    = p5_q;
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    steps_d = steps_q;
    stop_d  = stop_pend;
    mul_a   = '0;
    mul_b   = '0;

    unique case (state_q)
      StIdle: begin
        // A stop seen in IDLE, including one coincident with start, is discarded.
        stop_d = 1'b0;
        if (start_i) begin
          x_d     = x0_i;
          y_d     = y0_i;
          z_d     = z0_i;
          a_d     = a_i;
          b_d     = b_i;
          c_d     = c_i;
          h_d     = h_i;
          decim_d = (decim_i == '0) ? DECIM_W'(1) : decim_i;
          dcnt_d  = '0;
          steps_d = '0;
          state_d = StM1;
        end
      end
      StM1: begin
        mul_a   = h_q;
        mul_b   = sat2(y_q, z_q, 1'b0);
        p1_d    = mul_p;
        state_d = StM2;
      end
      StM2: begin
        mul_a   = a_q;
        mul_b   = y_q;
        p2_d    = mul_p;
        state_d = StM3;
      end
      StM3: begin
        mul_a   = h_q;
        mul_b   = sat2(x_q, p2_q, 1'b0);
        p3_d    = mul_p;
        state_d = StM4;
      end
      StM4: begin
        mul_a   = z_q;
        mul_b   = sat2(x_q, c_q, 1'b1);
        p4_d    = mul_p;
        state_d = StM5;
      end
      StM5: begin
        mul_a   = h_q;
        mul_b   = sat2(b_q, p4_q, 1'b0);
        p5_d    = mul_p;
        state_d = StUpd;
      end
      StUpd: begin
        x_d     = sat2(x_q, p1_q, 1'b1);
        y_d     = sat2(y_q, p3_q, 1'b0);
        z_d     = sat2(z_q, p5_q, 1'b0);
        steps_d = steps_q + CNT_W'(1);
        if (dcnt_inc == decim_q) begin
          dcnt_d  = '0;
          state_d = StOut;
        end else begin
          dcnt_d = dcnt_inc;
          if (stop_pend) begin
            stop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StM1;
          end
        end
      end
      StOut: begin
        if (ready_i) begin
          if (stop_pend) begin
            stop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StM1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      h_q     <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      p4_q    <= '0;
      p5_q    <= '0;
      decim_q <= '0;
      dcnt_q  <= '0;
      steps_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      h_q     <= h_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      p4_q    <= p4_d;
      p5_q    <= p5_d;
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
      steps_q <= steps_d;
      stop_q  <= stop_d;
    end
  end

  assign valid_o = (state_q == StOut);
  assign busy_o  = (state_q != StIdle);
  assign xn_o    = x_q;
  assign yn_o    = y_q;
  assign zn_o    = z_q;
  assign steps_o = steps_q;

endmodule

// File: tb/tb_rossler_tm.sv
// Directed and randomized bench for rossler_tm against a plain-arithmetic Euler model.
module tb_rossler_tm;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stop_i, ready_i;
  logic [31:0] a_i, b_i, c_i, h_i, x0_i, y0_i, z0_i;
  logic [7:0]  decim_i;
  logic        valid_o, busy_o;
  logic [31:0] xn_o, yn_o, zn_o, steps_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (real-valued Q11.20 integers held in longint).
  longint mx, my, mz, ma, mb, mc, mh;
  int     msteps, mdec;

  rossler_tm dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .h_i     (h_i),
    .x0_i    (x0_i),
    .y0_i    (y0_i),
    .z0_i    (z0_i),
    .decim_i (decim_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .xn_o    (xn_o),
    .yn_o    (yn_o),
    .zn_o    (zn_o),
    .steps_o (steps_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint mul(input longint a, input longint b);
    longint p;
    p = (a * b) >>> 20;
    return sat(p);
  endfunction

  function automatic longint s32(input logic [31:0] v);
    return longint'(signed'(v));
  endfunction

  task automatic model_step();
    longint nx, ny, nz;
    nx = sat(mx - mul(mh, sat(my + mz)));
    ny = sat(my + mul(mh, sat(mx + mul(ma, my))));
    nz = sat(mz + mul(mh, sat(mb + mul(mz, sat(mx - mc)))));
    mx = nx;
    my = ny;
    mz = nz;
    msteps++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag);
    logic [31:0] ex, ey, ez;
    ex = mx[31:0];
    ey = my[31:0];
    ez = mz[31:0];
    chk({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
    chk({tag, "_x"}, xn_o, ex);
    chk({tag, "_y"}, yn_o, ey);
    chk({tag, "_z"}, zn_o, ez);
    chk({tag, "_steps"}, steps_o, msteps);
  endtask

  task automatic configure(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] h, input logic [31:0] x0, input logic [31:0] y0,
                           input logic [31:0] z0, input logic [7:0] d);
    a_i = a; b_i = b; c_i = c; h_i = h; x0_i = x0; y0_i = y0; z0_i = z0; decim_i = d;
    ma = s32(a); mb = s32(b); mc = s32(c); mh = s32(h);
    mx = s32(x0); my = s32(y0); mz = s32(z0);
    msteps = 0;
    mdec = (d == 8'd0) ? 1 : int'(d);
  endtask

  task automatic cfg_t1(input logic [7:0] d);
    configure(32'h00033333, 32'h00033333, 32'h005B3333, 32'h000028F6,
              32'h00100000, 32'h0, 32'h0, d);
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Ticks until valid_o is seen or the budget runs out; n is the tick count.
  task automatic count_to_valid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_o && n < budget);
  endtask

  task automatic run_steps(input int k);
    for (int i = 0; i < k; i++) model_step();
  endtask

  initial begin
    int n;
    logic [31:0] cx, cy, cz;
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1;
    cfg_t1(8'd1);
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_steps", steps_o, 32'd0);
    chk("rst_x", xn_o, 32'd0);
    chk("rst_y", yn_o, 32'd0);
    chk("rst_z", zn_o, 32'd0);

    // Test 1: default Q11.20 run, latency, period, busy-start ignored.
    start_pulse();
    chk("t1_busy", {31'b0, busy_o}, 32'd1);
    chk("t1_load_x", xn_o, 32'h00100000);
    count_to_valid(50, n);
    chk("t1_lat", n, 32'd6);
    model_step();
    chk_sample("t1_s1");
    chk("t1_x_const", xn_o, 32'h00100000);
    chk("t1_y_const", yn_o, 32'h000028F6);
    chk("t1_z_const", zn_o, 32'h00000831);
    start_i = 1'b1; x0_i = 32'h12345678; a_i = 32'h00700000; h_i = 32'h00080000;
    count_to_valid(50, n);
    start_i = 1'b0;
    chk("t1_period", n, 32'd7);
    model_step();
    chk_sample("t1_s2");

    // Test 2: saturation clamps rather than wraps.
    do_reset();
    configure(32'h0, 32'h0, 32'h0, 32'h00100000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 8'd1);
    start_pulse();
    count_to_valid(50, n);
    chk("t2_lat", n, 32'd6);
    model_step();
    chk_sample("t2_s1");
    chk("t2_x_clamp", xn_o, 32'h80000000);

    // Test 3: backpressure.
    do_reset();
    cfg_t1(8'd1);
    ready_i = 1'b0;
    start_pulse();
    count_to_valid(50, n);
    chk("t3_lat", n, 32'd6);
    model_step();
    chk_sample("t3_s1");
    cx = xn_o; cy = yn_o; cz = zn_o;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold_valid", {31'b0, valid_o}, 32'd1);
      chk("t3_hold_x", xn_o, mx[31:0]);
      chk("t3_hold_y", yn_o, my[31:0]);
      chk("t3_hold_z", zn_o, mz[31:0]);
      chk("t3_hold_steps", steps_o, 32'd1);
    end
    ready_i = 1'b1;
    count_to_valid(50, n);
    chk("t3_period", n, 32'd7);
    model_step();
    chk_sample("t3_s2");

    // Test 4: decimation by 4, then decim 0 acting as 1.
    do_reset();
    cfg_t1(8'd4);
    start_pulse();
    count_to_valid(100, n);
    chk("t4_lat", n, 32'd24);
    run_steps(4);
    chk_sample("t4_s1");
    for (int s = 0; s < 2; s++) begin
      count_to_valid(100, n);
      chk("t4_period", n, 32'd25);
      run_steps(4);
      chk_sample("t4_sn");
    end
    do_reset();
    cfg_t1(8'd0);
    start_pulse();
    count_to_valid(50, n);
    chk("t4_d0_lat", n, 32'd6);
    model_step();
    chk_sample("t4_d0_s1");
    count_to_valid(50, n);
    chk("t4_d0_period", n, 32'd7);
    model_step();
    chk_sample("t4_d0_s2");

    // Test 5: stop in M3 with a sample due, then with no sample due.
    do_reset();
    cfg_t1(8'd1);
    start_pulse();
    tick();
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    count_to_valid(50, n);
    chk("t5_lat", n, 32'd3);
    model_step();
    chk_sample("t5_s1");
    tick();
    chk("t5_idle_busy", {31'b0, busy_o}, 32'd0);
    chk("t5_idle_valid", {31'b0, valid_o}, 32'd0);
    tick(); tick(); tick();
    chk("t5_hold_x", xn_o, mx[31:0]);
    chk("t5_hold_z", zn_o, mz[31:0]);
    chk("t5_hold_steps", steps_o, 32'd1);
    cfg_t1(8'd4);
    start_pulse();
    chk("t5_restart_steps", steps_o, 32'd0);
    chk("t5_restart_x", xn_o, 32'h00100000);
    tick();
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tick(); tick(); tick();
    model_step();
    chk("t5b_busy", {31'b0, busy_o}, 32'd0);
    chk("t5b_valid", {31'b0, valid_o}, 32'd0);
    chk("t5b_steps", steps_o, 32'd1);
    chk("t5b_x", xn_o, mx[31:0]);
    chk("t5b_y", yn_o, my[31:0]);

    // Stop during OUT keeps the sample; stop with start in IDLE is discarded.
    cfg_t1(8'd1);
    ready_i = 1'b0;
    start_pulse();
    count_to_valid(50, n);
    model_step();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk_sample("t5c_out_stop");
    ready_i = 1'b1;
    tick();
    chk("t5c_busy", {31'b0, busy_o}, 32'd0);
    cfg_t1(8'd1);
    stop_i = 1'b1;
    start_pulse();
    stop_i = 1'b0;
    count_to_valid(50, n);
    model_step();
    chk_sample("t5d_s1");
    count_to_valid(50, n);
    chk("t5d_period", n, 32'd7);
    model_step();
    chk_sample("t5d_s2");

    // Test 6: reset in M4, then reproduce test 1.
    do_reset();
    cfg_t1(8'd1);
    start_pulse();
    tick(); tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_busy", {31'b0, busy_o}, 32'd0);
    chk("t6_valid", {31'b0, valid_o}, 32'd0);
    chk("t6_steps", steps_o, 32'd0);
    chk("t6_x", xn_o, 32'd0);
    chk("t6_y", yn_o, 32'd0);
    chk("t6_z", zn_o, 32'd0);
    start_pulse();
    count_to_valid(50, n);
    chk("t6_lat", n, 32'd6);
    chk("t6_x1", xn_o, 32'h00100000);
    chk("t6_y1", yn_o, 32'h000028F6);
    chk("t6_z1", zn_o, 32'h00000831);
    chk("t6_steps1", steps_o, 32'd1);

    // Randomized configurations with random stalls.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] ra, rb, rc, rh, rx, ry, rz;
      logic [7:0]  rd;
      do_reset();
      if (r == 5) begin
        ra = $urandom; rb = $urandom; rc = $urandom; rh = $urandom;
        rx = $urandom; ry = $urandom; rz = $urandom;
      end else begin
        ra = $urandom_range(0, 32'h00080000);
        rb = $urandom_range(0, 32'h00080000);
        rc = $urandom_range(0, 32'h00800000);
        rh = $urandom_range(0, 32'h00008000);
        rx = $urandom_range(0, 32'h00FFFFFF) - 32'h00800000;
        ry = $urandom_range(0, 32'h00FFFFFF) - 32'h00800000;
        rz = $urandom_range(0, 32'h00FFFFFF) - 32'h00800000;
      end
      rd = 8'($urandom_range(0, 3));
      configure(ra, rb, rc, rh, rx, ry, rz, rd);
      ready_i = 1'b1;
      start_pulse();
      for (int s = 0; s < 4; s++) begin
        count_to_valid(200, n);
        chk("rnd_gap", n, (s == 0) ? mdec * 6 : mdec * 6 + 1);
        run_steps(mdec);
        chk_sample("rnd");
        ready_i = 1'b0;
        for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
          tick();
          chk("rnd_stall_x", xn_o, mx[31:0]);
        end
        ready_i = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
